// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - time-multiplexed AES SubBytes engine shared by the round datapath and key expansion

// AES forward S-box as a 256-entry constant; entry 0x00 sits in the top byte.
module sbox_lut (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a lives at bit offset (255 - a) * 8, and 255 - a is simply ~a.
    logic [10:0] base;

    assign base = {~a, 3'b000};
    assign y    = TABLE[base +: 8];

endmodule

module sbox_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    output logic [127:0] st_out,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_in,
    output logic         key_out_valid,
    output logic [31:0]  key_out,
    output logic         busy
);

    localparam int N_ST  = 16 / LANES;
    localparam int N_KEY = 4 / LANES;

    localparam logic [3:0] LAST_ST  = 4'(N_ST - 1);
    localparam logic [3:0] LAST_KEY = 4'(N_KEY - 1);
    localparam logic [3:0] LANES4   = 4'(LANES);

    localparam logic GRANT_ST  = 1'b0;
    localparam logic GRANT_KEY = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN_ST,
        RUN_KEY
    } state_t;

    state_t state;
    logic [3:0] cnt;
    logic       last_grant;

    // Work buffer: element 15 is byte0 (MSB). A key job sits in elements
    // 15..12 so both job types share the same byte addressing.
    logic [15:0][7:0]      work;
    logic [15:0][7:0]      work_nx;
    logic [LANES-1:0][7:0] sb_in;
    logic [LANES-1:0][7:0] sb_out;

    logic [3:0] base;
    logic       last_chunk;
    logic       grant_st;
    logic       grant_key;

    assign base = cnt * LANES4;

    assign last_chunk = (state == RUN_ST) ? (cnt == LAST_ST) : (cnt == LAST_KEY);

    // Key wins a tie only when the state side was granted last time, so ties alternate.
    assign grant_key = key_valid && (!st_valid || (last_grant == GRANT_ST));
    assign grant_st  = st_valid && !grant_key;

    assign st_ready  = (state == IDLE) && !rst;
    assign key_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            sbox_lut u_sbox (
                .a (sb_in[g]),
                .y (sb_out[g])
            );
        end
    endgenerate

    // Gather the current chunk into the shared sboxes and splice the results back in place.
    always_comb begin
        work_nx = work;
        sb_in   = '0;
        for (int l = 0; l < LANES; l++) begin
            sb_in[l] = work[4'd15 - (base + 4'(l))];
        end
        for (int l = 0; l < LANES; l++) begin
            work_nx[4'd15 - (base + 4'(l))] = sb_out[l];
        end
    end

    // Arbitration, chunk iteration and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            last_grant    <= GRANT_ST;
            work          <= '0;
            st_out        <= '0;
            key_out       <= '0;
            st_out_valid  <= 1'b0;
            key_out_valid <= 1'b0;
        end else begin
            st_out_valid  <= 1'b0;
            key_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_key) begin
                        work       <= {key_in, 96'd0};
                        cnt        <= 4'd0;
                        last_grant <= GRANT_KEY;
                        state      <= RUN_KEY;
                    end else if (grant_st) begin
                        work       <= st_in;
                        cnt        <= 4'd0;
                        last_grant <= GRANT_ST;
                        state      <= RUN_ST;
                    end
                end
                RUN_ST, RUN_KEY: begin
                    work <= work_nx;
                    cnt  <= cnt + 4'd1;
                    if (last_chunk) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                        if (state == RUN_ST) begin
                            st_out       <= work_nx;
                            st_out_valid <= 1'b1;
                        end else begin
                            key_out       <= work_nx[15:12];
                            key_out_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - scoreboard bench for sbox_sched
module tb_sbox_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         st_valid, st_ready, st_out_valid;
    logic [127:0] st_in, st_out;
    logic         key_valid, key_ready, key_out_valid;
    logic [31:0]  key_in, key_out;
    logic         busy;

    logic         x_st_valid, x_key_valid;
    logic [127:0] x_st_in;
    logic [31:0]  x_key_in;

    logic         l1_st_ready, l1_st_ov, l1_key_ready, l1_key_ov, l1_busy;
    logic [127:0] l1_st_out;
    logic [31:0]  l1_key_out;
    logic         l2_st_ready, l2_st_ov, l2_key_ready, l2_key_ov, l2_busy;
    logic [127:0] l2_st_out;
    logic [31:0]  l2_key_out;

    sbox_sched #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
        .st_out_valid(st_out_valid), .st_out(st_out),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .key_out_valid(key_out_valid), .key_out(key_out),
        .busy(busy)
    );

    sbox_sched #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst),
        .st_valid(x_st_valid), .st_ready(l1_st_ready), .st_in(x_st_in),
        .st_out_valid(l1_st_ov), .st_out(l1_st_out),
        .key_valid(x_key_valid), .key_ready(l1_key_ready), .key_in(x_key_in),
        .key_out_valid(l1_key_ov), .key_out(l1_key_out),
        .busy(l1_busy)
    );

    sbox_sched #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst),
        .st_valid(x_st_valid), .st_ready(l2_st_ready), .st_in(x_st_in),
        .st_out_valid(l2_st_ov), .st_out(l2_st_out),
        .key_valid(x_key_valid), .key_ready(l2_key_ready), .key_in(x_key_in),
        .key_out_valid(l2_key_ov), .key_out(l2_key_out),
        .busy(l2_busy)
    );

    typedef struct {
        logic [127:0] d;
        logic [127:0] e;
    } req_t;

    typedef struct {
        logic [127:0] v;
        int           c;
    } exp_t;

    req_t st_q[$];
    req_t key_q[$];
    exp_t st_exp[$];
    exp_t key_exp[$];

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic         m_last;
    logic [127:0] st_hold;
    logic [31:0]  key_hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (st_q.size() == 0 && key_q.size() == 0 && st_exp.size() == 0 &&
                key_exp.size() == 0 && !busy && !st_valid && !key_valid)
                break;
        end
        if (n == budget) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    // Driver: presents queued jobs, predicts the grant, pushes expectations.
    initial begin
        logic gs, gk;
        forever begin
            @(negedge clk);
            gs = 1'b0;
            gk = 1'b0;
            if (rst) begin
                m_last = 1'b0;
            end else if (st_ready) begin
                gk = key_valid && (!st_valid || m_last == 1'b0);
                gs = st_valid && !gk;
                if (gk) begin
                    key_exp.push_back('{key_q[0].e, cyc + 2});
                    m_last = 1'b1;
                end
                if (gs) begin
                    st_exp.push_back('{st_q[0].e, cyc + 5});
                    m_last = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            if (gk) begin
                void'(key_q.pop_front());
                key_valid = 1'b0;
            end
            if (gs) begin
                void'(st_q.pop_front());
                st_valid = 1'b0;
            end
            if (!key_valid) begin
                if (key_q.size() > 0) begin
                    key_in    = key_q[0].d[31:0];
                    key_valid = 1'b1;
                end else begin
                    key_in = $urandom;
                end
            end
            if (!st_valid) begin
                if (st_q.size() > 0) begin
                    st_in    = st_q[0].d;
                    st_valid = 1'b1;
                end else begin
                    st_in = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (st_out_valid) begin
                if (st_exp.size() == 0) begin
                    chk("st_unexpected", st_out_valid, 1'b0);
                end else begin
                    e = st_exp.pop_front();
                    chk("st_out", st_out, e.v);
                    chk("st_cycle", cyc, e.c);
                    st_hold = e.v;
                end
                chk("key_out_hold", key_out, key_hold);
            end
            if (key_out_valid) begin
                if (key_exp.size() == 0) begin
                    chk("key_unexpected", key_out_valid, 1'b0);
                end else begin
                    e = key_exp.pop_front();
                    chk("key_out", key_out, e.v);
                    chk("key_cycle", cyc, e.c);
                    key_hold = e.v[31:0];
                end
                chk("st_out_hold", st_out, st_hold);
            end
            if (st_out_valid && key_out_valid)
                chk("dual_valid", 2'b11, 2'b00);
            if (busy)
                chk("ready_in_run", {st_ready, key_ready}, 2'b00);
        end
    end

    initial begin
        int t0, g1, g2, k1, k2;
        logic [127:0] d1, d2;
        logic [31:0]  kd1, kd2;

        rst = 1'b1;
        st_valid = 1'b0;
        key_valid = 1'b0;
        st_in = '0;
        key_in = '0;
        x_st_valid = 1'b0;
        x_key_valid = 1'b0;
        x_st_in = '0;
        x_key_in = '0;
        m_last = 1'b0;
        st_hold = '0;
        key_hold = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", st_ready, 1'b0);
        chk("rst_key_ready", key_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_st_out_valid", st_out_valid, 1'b0);
        chk("rst_key_out_valid", key_out_valid, 1'b0);
        chk("rst_st_out", st_out, 128'd0);
        chk("rst_key_out", key_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {st_ready, key_ready}, 2'b11);

        // Single state job, then a single key job.
        st_q.push_back('{128'h000102030405060708090a0b0c0d0e0f,
                         128'h637c777bf26b6fc53001672bfed7ab76});
        wait_idle(40);
        key_q.push_back('{{96'd0, 32'h5301ff00}, {96'd0, 32'hed7c1663}});
        wait_idle(40);

        // Back-to-back state jobs contending with a key job.
        st_q.push_back('{{16{8'h53}}, {16{8'hed}}});
        st_q.push_back('{{16{8'hff}}, {16{8'h16}}});
        key_q.push_back('{{96'd0, 32'h00000000}, {96'd0, 32'h63636363}});
        wait_idle(80);

        // Reset in the third RUN_ST cycle discards the job and clears outputs.
        st_q.push_back('{128'd0, {16{8'h63}}});
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        chk("mid_job_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        st_exp.delete();
        st_hold = '0;
        key_hold = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {st_ready, key_ready}, 2'b11);
        chk("post_rst_st_out", st_out, 128'd0);
        chk("post_rst_key_out", key_out, 32'd0);
        chk("post_rst_busy", busy, 1'b0);
        repeat (8) @(negedge clk);

        // Ties from reset: key, state, key, state.
        st_q.push_back('{128'h000102030405060708090a0b0c0d0e0f,
                         128'h637c777bf26b6fc53001672bfed7ab76});
        st_q.push_back('{128'd0, {16{8'h63}}});
        key_q.push_back('{{96'd0, 32'h5301ff00}, {96'd0, 32'hed7c1663}});
        key_q.push_back('{{96'd0, 32'hffffffff}, {96'd0, 32'h16161616}});
        wait_idle(100);

        // Narrow-lane builds: latency and result.
        @(posedge clk);
        #1;
        x_st_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        chk("lanes_st_ready", {l1_st_ready, l2_st_ready}, 2'b11);
        @(posedge clk);
        #1;
        x_st_valid = 1'b0;
        g1 = -1;
        g2 = -1;
        d1 = '0;
        d2 = '0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (l1_st_ov) begin
                g1 = cyc - t0;
                d1 = l1_st_out;
            end
            if (l2_st_ov) begin
                g2 = cyc - t0;
                d2 = l2_st_out;
            end
        end
        chk("l1_st_latency", g1, 17);
        chk("l2_st_latency", g2, 9);
        chk("l1_st_out", d1, {16{8'h63}});
        chk("l2_st_out", d2, {16{8'h63}});

        @(posedge clk);
        #1;
        x_key_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk);
        #1;
        x_key_valid = 1'b0;
        k1 = -1;
        k2 = -1;
        kd1 = '0;
        kd2 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l1_key_ov) begin
                k1 = cyc - t0;
                kd1 = l1_key_out;
            end
            if (l2_key_ov) begin
                k2 = cyc - t0;
                kd2 = l2_key_out;
            end
        end
        chk("l1_key_latency", k1, 5);
        chk("l2_key_latency", k2, 3);
        chk("l1_key_out", kd1, 32'h63636363);
        chk("l2_key_out", kd2, 32'h63636363);
        chk("l1_st_out_held", l1_st_out, {16{8'h63}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
